// File: rtl/dadda_mul_share_ctrl_pkg.sv
// Shared definitions for the dadda_mul sharing controller.
//   state_t : controller FSM states (IDLE -> MUL -> RESP -> IDLE)
//   W_DEF   : default operand/sum width of the shared multiplier
//   clog2   : ceiling log2, used for id and settle-counter widths
package dadda_ctrl_pkg;

  localparam int unsigned W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/dadda_mul_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req     : request vector
//   ptr     : highest-priority index for this decision
//   gnt     : one-hot grant, first set req searching ptr, ptr+1, ... mod NREQ
//   gnt_idx : binary index of the granted requester (0 when no grant)
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_idx
);

  always_comb begin
    int unsigned idx;
    logic        found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        found        = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/dadda_mul_share_ctrl.sv
// Time-shares one external combinational dadda_mul among NREQ requesters.
// One operation in flight; round-robin grant; operands are registered onto
// mul_* and held MUL_CYCLES cycles before the result is captured and offered
// on a valid/ready response port tagged with the requester index.
//   clk, rst_n          : clock, asynchronous active-low reset
//   req_valid/ready     : per-requester request handshake (ready is one-hot)
//   req_a/req_b/req_cin : packed operands, requester i at [i*W +: W]
//   mul_a/mul_b/mul_cin : registered operands to dadda_mul
//   mul_sum/mul_carry   : dadda_mul result
//   rsp_valid/ready     : response handshake
//   rsp_id/sum/carry    : response payload
//   busy                : operation in MUL or RESP
module dadda_mul_share_ctrl
  import dadda_ctrl_pkg::*;
#(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned W          = W_DEF,
  parameter int unsigned MUL_CYCLES = 1,
  parameter int unsigned IDW        = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ-1:0]   req_cin,
  output logic [W-1:0]      mul_a,
  output logic [W-1:0]      mul_b,
  output logic              mul_cin,
  input  logic [W-1:0]      mul_sum,
  input  logic              mul_carry,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_sum,
  output logic              rsp_carry,
  output logic              busy
);

  localparam int unsigned CW = (MUL_CYCLES > 1) ? clog2(MUL_CYCLES) : 1;

  state_t          state, state_nx;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  id;
  logic [CW-1:0]   cnt;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_idx;
  logic            accept;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req     (req_valid),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Grant only while idle; held off during reset so req_ready reads 0 there.
  assign req_ready = (state == ST_IDLE && rst_n) ? gnt : '0;
  assign accept    = |req_ready;
  assign busy      = (state != ST_IDLE);

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (accept)       state_nx = ST_MUL;
      ST_MUL:  if (cnt == '0)    state_nx = ST_RESP;
      ST_RESP: if (rsp_ready)    state_nx = ST_IDLE;
      default:                   state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      id        <= '0;
      cnt       <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      mul_cin   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
      rsp_carry <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            mul_a   <= req_a[gnt_idx*W +: W];
            mul_b   <= req_b[gnt_idx*W +: W];
            mul_cin <= req_cin[gnt_idx];
            id      <= gnt_idx;
            ptr     <= (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
            cnt     <= CW'(MUL_CYCLES-1);
          end
        end
        ST_MUL: begin
          if (cnt == '0) begin
            rsp_sum   <= mul_sum;
            rsp_carry <= mul_carry;
            rsp_id    <= id;
            rsp_valid <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
